add_tree_pipe: RTL and testbench

- Parametrised, pipelined multi-operand modular adder. Successor to the fixed 5-input, 32-bit combinational adder used in the SHA-256 datapath (T1 = h + Σ1 + Ch + K + W).
- Adds N operands of W bits through a registered binary adder tree with valid/ready flow control.
- Per-operand enable mask, full-width (non-truncated) sum, and a pass-through tag so the round controller can track which round each result belongs to.

---
 rtl/sha_pkg.sv | 39 +++
 rtl/add_tree_level.sv | 58 +++++
 rtl/add_tree_pipe.sv | 77 +++++++
 tb/tb_add_tree_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared constants and elaboration-time helpers for the SHA-256 datapath blocks.
// The tree helpers describe how many entries each adder-tree level holds and where it sits in a flat bus.
package sha_pkg;

  localparam int SHA_WORD_W      = 32;
  localparam int SHA_ROUND_TAG_W = 6;

  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

  // A single operand still gets one registered level.
  function automatic int tree_depth(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int tree_entries(input int n, input int level);
    return (n + (1 << level) - 1) >> level;
  endfunction

  // Level j entries are w+j bits wide; levels are packed back to back starting at level 0.
  function automatic int tree_offset(input int n, input int w, input int level);
    int offset;
    offset = 0;
    for (int j = 0; j < level; j++) begin
      offset = offset + tree_entries(n, j) * (w + j);
    end
    return offset;
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered level of the adder tree: pairwise sums widened by one bit, plus its valid/ready slice.
// An odd trailing entry is zero-extended and passed through unchanged.
module add_tree_level #(
  parameter  int N_IN  = 5,
  parameter  int W_IN  = 32,
  parameter  int W_OUT = 33,
  parameter  int TAG_W = 6,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*W_IN-1:0]     in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*W_OUT-1:0]   out_data,
  output logic [TAG_W-1:0]         out_tag
);

  logic [N_OUT*W_OUT-1:0] sum_next;
  logic                   valid_q;
  logic [N_OUT*W_OUT-1:0] data_q;
  logic [TAG_W-1:0]       tag_q;

  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    if (2 * j + 1 < N_IN) begin : g_add
      assign sum_next[j*W_OUT +: W_OUT] = W_OUT'(in_data[2*j*W_IN +: W_IN])
                                        + W_OUT'(in_data[(2*j+1)*W_IN +: W_IN]);
    end else begin : g_pass
      assign sum_next[j*W_OUT +: W_OUT] = W_OUT'(in_data[2*j*W_IN +: W_IN]);
    end
  end

  // An empty stage, or one whose content leaves this cycle, can take new data.
  assign in_ready = !valid_q || out_ready;

  // Data and tag only move on a real transfer, so a bubble never disturbs the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= sum_next;
        tag_q  <= in_tag;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined N-operand modular adder with per-operand mask, exact-width sum and a pass-through round tag.
// Each tree level is one add_tree_level; all levels share one flat data bus and a ready chain.
module add_tree_pipe
  import sha_pkg::*;
#(
  parameter  int W     = SHA_WORD_W,
  parameter  int N     = 5,
  parameter  int TAG_W = SHA_ROUND_TAG_W,
  localparam int LVL   = tree_depth(N),
  localparam int FW    = W + clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     in_data,
  input  logic [N-1:0]       in_mask,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic [FW-1:0]      out_sum_full,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int TOTAL_W = tree_offset(N, W, LVL + 1);
  localparam int LAST_W  = W + LVL;
  localparam int LAST_OFF = tree_offset(N, W, LVL);

  logic [TOTAL_W-1:0]          tree_data;
  logic [LVL:0]                stage_valid;
  logic [LVL:0]                stage_ready;
  logic [LVL:0][TAG_W-1:0]     stage_tag;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign tree_data[i*W +: W] = in_data[i*W +: W] & {W{in_mask[i]}};
  end

  assign stage_valid[0]   = in_valid;
  assign stage_tag[0]     = in_tag;
  assign stage_ready[LVL] = out_ready;

  for (genvar k = 1; k <= LVL; k++) begin : g_lvl
    localparam int NI    = tree_entries(N, k - 1);
    localparam int NO    = tree_entries(N, k);
    localparam int OFF_I = tree_offset(N, W, k - 1);
    localparam int OFF_O = tree_offset(N, W, k);

    add_tree_level #(
      .N_IN  (NI),
      .W_IN  (W + k - 1),
      .W_OUT (W + k),
      .TAG_W (TAG_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (stage_valid[k-1]),
      .in_ready  (stage_ready[k-1]),
      .in_data   (tree_data[OFF_I +: NI*(W+k-1)]),
      .in_tag    (stage_tag[k-1]),
      .out_valid (stage_valid[k]),
      .out_ready (stage_ready[k]),
      .out_data  (tree_data[OFF_O +: NO*(W+k)]),
      .out_tag   (stage_tag[k])
    );
  end

  // The last level holds exactly one entry; widen it to the advertised full-sum width.
  assign out_sum_full = FW'(tree_data[LAST_OFF +: LAST_W]);
  assign out_sum      = out_sum_full[W-1:0];
  assign out_tag      = stage_tag[LVL];
  assign out_valid    = stage_valid[LVL];
  assign in_ready     = stage_ready[0];
  assign busy         = |stage_valid[LVL:1];

endmodule

// File: tb/tb_add_tree_pipe.sv
// Directed bench for add_tree_pipe at N=5, W=32: latency, streaming, masks, backpressure, bubbles, mid-flight reset.
// Expected sums are computed by the bench from the operands it drives.
module tb_add_tree_pipe;

  localparam int W     = 32;
  localparam int N     = 5;
  localparam int TAG_W = 6;
  localparam int FW    = 35;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     in_data;
  logic [N-1:0]       in_mask;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_sum;
  logic [FW-1:0]      out_sum_full;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  int checks = 0;
  int errors = 0;

  add_tree_pipe #(.W(W), .N(N), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_mask      (in_mask),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_sum_full (out_sum_full),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] data, input logic [N-1:0] mask,
                               input logic [TAG_W-1:0] tag, input logic valid);
    in_data  = data;
    in_mask  = mask;
    in_tag   = tag;
    in_valid = valid;
  endtask

  // Caller has already advanced one falling edge past the input transfer.
  task automatic waitOutput(input int budget, output int cycles);
    cycles = 1;
    while (!out_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) checkOutput("wait_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  function automatic logic [N*W-1:0] rampData(input int k);
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(k + i);
    return d;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int sent;
    int got;
    int k;
    logic [FW-1:0]    expFull[$];
    logic [TAG_W-1:0] expTag[$];
    logic [N*W-1:0]   rndData;
    logic [N-1:0]     rndMask;
    logic [FW-1:0]    acc;

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("rst_out_sum_full", 64'(out_sum_full), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones operands: latency and carry into the full-width sum
    applyStimulus({N{32'hFFFF_FFFF}}, 5'b11111, 6'h2A, 1'b1);
    @(negedge clk);
    applyStimulus('0, '0, '0, 1'b0);
    waitOutput(10, cycles);
    checkOutput("ones_latency", 64'(cycles), 64'd3);
    checkOutput("ones_out_sum", 64'(out_sum), 64'hFFFF_FFFB);
    checkOutput("ones_out_sum_full", 64'(out_sum_full), 64'h4_FFFF_FFFB);
    checkOutput("ones_out_tag", 64'(out_tag), 64'h2A);
    @(negedge clk);

    // Back-to-back stream of 100 sets; result k appears three edges after it is driven
    for (int c = 0; c < 103; c++) begin
      if (c >= 3) begin
        k = c - 3;
        checkOutput("b2b_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("b2b_sum", 64'(out_sum), 64'(5 * k + 10));
        checkOutput("b2b_tag", 64'(out_tag), 64'(k % 64));
      end else begin
        checkOutput("b2b_idle", {63'd0, out_valid}, 64'd0);
      end
      if (c < 100) applyStimulus(rampData(c), 5'b11111, TAG_W'(c), 1'b1);
      else         in_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b_drained", {63'd0, out_valid}, 64'd0);

    // Masks: operands 1..5 with 10101 give 1+3+5, then an all-zero mask with junk data
    applyStimulus(rampData(1), 5'b10101, 6'd1, 1'b1);
    @(negedge clk);
    applyStimulus({N{32'hFFFF_FFFF}}, 5'b00000, 6'd2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    waitOutput(10, cycles);
    checkOutput("mask_sum", 64'(out_sum), 64'd9);
    checkOutput("mask_tag", 64'(out_tag), 64'd1);
    @(negedge clk);
    checkOutput("mask0_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("mask0_sum_full", 64'(out_sum_full), 64'd0);
    checkOutput("mask0_tag", 64'(out_tag), 64'd2);
    @(negedge clk);

    // Backpressure: 10 sets, out_ready low for cycles 4..9
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      out_ready = !(c >= 4 && c < 10);
      #1;
      if (c >= 4 && c < 10) begin
        checkOutput("bp_stall_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("bp_stall_sum", 64'(out_sum), 64'(5 * (200 + got) + 10));
        checkOutput("bp_stall_tag", 64'(out_tag), 64'(10 + got));
        if (c >= 6) checkOutput("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
      end
      if (c == 10) checkOutput("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
      if (out_valid && out_ready) begin
        checkOutput("bp_sum", 64'(out_sum), 64'(5 * (200 + got) + 10));
        checkOutput("bp_tag", 64'(out_tag), 64'(10 + got));
        got++;
      end
      if (sent < 10) begin
        applyStimulus(rampData(200 + sent), 5'b11111, TAG_W'(10 + sent), 1'b1);
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("bp_count", 64'(got), 64'd10);
    @(negedge clk);
    checkOutput("bp_no_dup", {63'd0, out_valid}, 64'd0);
    checkOutput("bp_idle_busy", {63'd0, busy}, 64'd0);

    // Random bubbles and random backpressure against a queue of expected results
    void'($urandom(32'd20240611));
    sent = 0;
    got  = 0;
    for (int c = 0; c < 600 && got < 40; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (expFull.size() == 0) begin
          checkOutput("rnd_unexpected", {63'd0, out_valid}, 64'd0);
        end else begin
          checkOutput("rnd_sum_full", 64'(out_sum_full), 64'(expFull[0]));
          checkOutput("rnd_sum", 64'(out_sum), 64'(expFull[0][W-1:0]));
          checkOutput("rnd_tag", 64'(out_tag), 64'(expTag[0]));
          void'(expFull.pop_front());
          void'(expTag.pop_front());
        end
        got++;
      end
      if (sent < 40 && $urandom_range(0, 1) == 1) begin
        acc = '0;
        rndMask = N'($urandom());
        for (int i = 0; i < N; i++) begin
          rndData[i*W +: W] = $urandom();
          if (rndMask[i]) acc = acc + FW'(rndData[i*W +: W]);
        end
        applyStimulus(rndData, rndMask, TAG_W'(sent), 1'b1);
        if (in_ready) begin
          expFull.push_back(acc);
          expTag.push_back(TAG_W'(sent));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("rnd_count", 64'(got), 64'd40);

    // Mid-flight reset with three sets held in the stalled pipe
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      applyStimulus(rampData(300 + j), 5'b11111, TAG_W'(50 + j), 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("flight_busy", {63'd0, busy}, 64'd1);
    checkOutput("flight_valid", {63'd0, out_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("arst_busy", {63'd0, busy}, 64'd0);
    checkOutput("arst_out_sum_full", 64'(out_sum_full), 64'd0);
    checkOutput("arst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
    end
    applyStimulus(rampData(7), 5'b11111, 6'h15, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    waitOutput(10, cycles);
    checkOutput("post_rst_latency", 64'(cycles), 64'd3);
    checkOutput("post_rst_sum", 64'(out_sum), 64'd45);
    checkOutput("post_rst_tag", 64'(out_tag), 64'h15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
